// File: rtl/eret_sequencer_pkg.sv
// rtl/eret_sequencer_pkg.sv - shared types and helpers for the return-from-exception sequencer
package eret_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_RESTORE  = 2'd2,
        ST_REDIRECT = 2'd3
    } eret_state_e;

    localparam logic MODE_USER = 1'b1;
    localparam logic MODE_SYS  = 1'b0;

    // Width of the drain cycle counter; covers the full 1..255 timeout range.
    localparam int DRAIN_CNT_W = 8;

    // Masked SR restore: bits inside the mask come from the saved copy, the rest keep their live value.
    function automatic logic [31:0] sr_merge(
        input logic [31:0] saved,
        input logic [31:0] cur,
        input logic [31:0] mask
    );
        return (saved & mask) | (cur & ~mask);
    endfunction

endpackage

// File: rtl/eret_drain_counter.sv
// rtl/eret_drain_counter.sv - saturating drain cycle counter with terminal-count flag
module eret_drain_counter #(
    parameter int                   WIDTH    = 8,
    parameter logic [WIDTH-1:0]     TERMINAL = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/eret_sequencer.sv
// rtl/eret_sequencer.sv - drains the pipe, restores SR/mode and redirects fetch on eret
module eret_sequencer
    import eret_sequencer_pkg::*;
#(
    parameter int          DRAIN_TIMEOUT = 16,
    parameter logic [31:0] SR_MASK       = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eret,
    input  logic        mode,
    input  logic [31:0] sr_cur,
    input  logic [31:0] esr,
    input  logic [31:0] epc,
    input  logic        emode,
    input  logic        pipe_busy,
    input  logic        fetch_ready,
    input  logic        jisr,
    output logic        stall,
    output logic        flush,
    output logic        sr_we,
    output logic [31:0] sr_wdata,
    output logic        mode_we,
    output logic        mode_wdata,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        ill_eret,
    output logic        drain_timeout,
    output logic        busy
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

    eret_state_e state;
    eret_state_e state_d;

    logic [31:0] esr_snap;
    logic [31:0] epc_snap;
    logic        emode_snap;

    logic accept;
    logic user_eret;
    logic timeout_hit;
    logic cnt_tc;

    // jisr always wins over a new eret; only IDLE looks at eret at all.
    assign accept    = (state == ST_IDLE) && eret && !jisr && (mode == MODE_SYS);
    assign user_eret = (state == ST_IDLE) && eret && !jisr && (mode == MODE_USER);

    eret_drain_counter #(
        .WIDTH    (DRAIN_CNT_W),
        .TERMINAL (DRAIN_LAST)
    ) u_drain_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (state == ST_DRAIN),
        .tc     (cnt_tc)
    );

    // Next-state selection; an interrupt aborts DRAIN and REDIRECT, while RESTORE completes its strobes first.
    always_comb begin
        state_d     = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (jisr) begin
                    state_d = ST_IDLE;
                end else if (!pipe_busy) begin
                    state_d = ST_RESTORE;
                end else if (cnt_tc) begin
                    state_d     = ST_RESTORE;
                    timeout_hit = 1'b1;
                end
            end
            ST_RESTORE: begin
                state_d = jisr ? ST_IDLE : ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (jisr || fetch_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, snapshot and every output are registered from the next state, so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            esr_snap      <= '0;
            epc_snap      <= '0;
            emode_snap    <= 1'b0;
            stall         <= 1'b0;
            flush         <= 1'b0;
            sr_we         <= 1'b0;
            sr_wdata      <= '0;
            mode_we       <= 1'b0;
            mode_wdata    <= 1'b0;
            redir_valid   <= 1'b0;
            redir_pc      <= '0;
            ill_eret      <= 1'b0;
            drain_timeout <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                esr_snap   <= esr;
                epc_snap   <= epc;
                emode_snap <= emode;
            end
            stall         <= (state_d != ST_IDLE);
            busy          <= (state_d != ST_IDLE);
            flush         <= (state_d == ST_DRAIN);
            sr_we         <= (state_d == ST_RESTORE);
            mode_we       <= (state_d == ST_RESTORE);
            sr_wdata      <= (state_d == ST_RESTORE) ? sr_merge(esr_snap, sr_cur, SR_MASK) : '0;
            mode_wdata    <= (state_d == ST_RESTORE) ? emode_snap : 1'b0;
            redir_valid   <= (state_d == ST_REDIRECT);
            redir_pc      <= (state_d == ST_REDIRECT) ? epc_snap : '0;
            ill_eret      <= user_eret;
            drain_timeout <= timeout_hit;
        end
    end

endmodule
